icache_direct_mapped: RTL and testbench
=======================================

Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream consumer) and the memory controller (downstream supplier).
- Serves one 32-bit word per fetcher query.
- On a miss, refills a whole line word-by-word from the memory controller, then answers the query.
- Holds no dirty state; never writes memory.

Parameters:
- INDEX_WIDTH, 4, log2(number of lines); 16 lines.
- OFFSET_WIDTH, 2, log2(words per line); 4 words (16 B) per line.
- TAG_WIDTH, 32-2-INDEX_WIDTH-OFFSET_WIDTH (derived localparam), tag bits per line.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; 0 freezes all state.
- icache_query_en  input  1  fetcher requests the word at icache_query_pc; held until served or withdrawn.
- icache_query_pc  input  32  fetch address; bits [1:0] ignored.
- icache_data_en  output  1  one-cycle pulse: response valid.
- icache_addr_comfirm  output  32  pc the response belongs to (bits [1:0] forced 0).
- icache_data  output  32  instruction word.
- mem_req_en  output  1  word-read request to memory controller; held until mem_data_en.
- mem_req_addr  output  32  word-aligned read address.
- mem_data_en  input  1  one-cycle pulse: mem_data valid for the outstanding request.
- mem_data  input  32  returned word.

Behaviour:
- Address split: offset = pc[OFFSET_WIDTH+1:2]; index = next INDEX_WIDTH bits; tag = pc[31 : INDEX_WIDTH+OFFSET_WIDTH+2].
- Storage: data array, tag array, valid bit per line.
- Reset (async): all valid bits 0, state IDLE. Outputs: icache_data_en=0, icache_addr_comfirm=0, icache_data=0, mem_req_en=0, mem_req_addr=0. Data/tag arrays need no reset.
- rdy_in=0: no state, array, or output register changes. Reset still takes effect.
- States:
  - IDLE: accepts a query when icache_query_en=1 and icache_data_en=0. Lookup is combinational on icache_query_pc.
    - Hit: next edge sets icache_data_en=1 with the word and pc; state stays IDLE. Hit latency is 1 cycle.
    - Miss: latch pc into miss_pc, clear the line's valid bit, set mem_req_en=1, mem_req_addr={miss_pc line base, word 0}, go to REFILL.
  - REFILL: on each mem_data_en, write mem_data into the line at the refill counter and increment the counter.
    - If words remain: mem_req_addr += 4, mem_req_en stays 1.
    - After the last word: mem_req_en=0, write tag, set valid, go to RESPOND.
  - RESPOND: if icache_query_en=1 and icache_query_pc[31:2]==miss_pc[31:2], pulse icache_data_en with the requested word (miss latency = refill + 1). Otherwise no pulse. Then go to IDLE.
- icache_data_en is high for exactly one cycle per served query. While it is high, a still-asserted query_en is not re-accepted; this covers the fetcher dropping query_en one edge late.
- Query withdrawn or pc changed during REFILL (fetcher flush):
  - The refill always completes; memory transactions are never aborted.
  - No stale response is issued.
  - The new pc is looked up in IDLE afterwards.
- mem_data_en while mem_req_en=0 is ignored.
- The refill counter wraps at 2^OFFSET_WIDTH. Address arithmetic is 32-bit modulo. A line at the top of the address space (0xFFFFFFF0) refills correctly.
- Simultaneous last-word mem_data_en and query change: line is filled and validated; the response decision uses the query seen in RESPOND.

Optional Feature:
- Macro ICACHE_PERF_COUNTERS_EN.
- Defined: adds outputs perf_hit_count[31:0] and perf_miss_count[31:0], reset to 0.
  - Hit counter increments once per hit accepted in IDLE.
  - Miss counter increments once per REFILL entry.
  - Both saturate at 0xFFFFFFFF and freeze while rdy_in=0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Cold miss: reset, query pc=0x00000008 → mem_req_addr 0x0,0x4,0x8,0xC in order; after 4th mem_data_en, one icache_data_en pulse with data = word returned for 0x8, addr_comfirm=0x8.
- Hit after fill: query 0x0000000C held → icache_data_en exactly 1 cycle after acceptance, no mem_req_en, single pulse even though query_en drops one edge late.
- Conflict eviction: fill line for 0x00000000, then query 0x00000100 (same index, 16 lines × 16 B) → miss, refill 0x100–0x10C; re-query 0x0 → miss again.
- Flush mid-refill: miss on 0x20, drop query_en after 2nd word → refill finishes 0x2C, no icache_data_en; then query 0x24 → hit in 1 cycle.
- rdy_in stall: drop rdy_in for 5 cycles during REFILL with mem_data_en pulses ignored by the bench → mem_req_addr unchanged, refill resumes correctly.
- Async reset mid-refill: assert rst_in between clock edges → mem_req_en and icache_data_en go 0 immediately; prior line queried afterwards misses.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// ----------------------------------------------------------------------------
// icache_direct_mapped
//
// Direct-mapped, read-only instruction cache. It sits between the instruction
// fetcher (which issues word queries) and the memory controller (which supplies
// refill words one at a time). It never writes memory and holds no dirty state.
//
// Geometry: 2^INDEX_WIDTH lines of 2^OFFSET_WIDTH 32-bit words each. The pc is
// split as  tag = pc[31:INDEX_WIDTH+OFFSET_WIDTH+2],
//           index = next INDEX_WIDTH bits,
//           offset = pc[OFFSET_WIDTH+1:2],  pc[1:0] ignored.
//
// Ports:
//   clk_in               clock, rising edge
//   rst_in               asynchronous active-high reset
//   rdy_in               global ready; 0 freezes every register and array
//   icache_query_en      fetcher request, held until served or withdrawn
//   icache_query_pc      fetch address
//   icache_data_en       one-cycle response pulse
//   icache_addr_comfirm  word-aligned pc the response belongs to
//   icache_data          instruction word
//   mem_req_en           word read request, held until mem_data_en
//   mem_req_addr         word-aligned read address
//   mem_data_en          one-cycle pulse, mem_data valid
//   mem_data             returned word
//
// Optional feature (macro ICACHE_PERF_COUNTERS_EN):
//   perf_hit_count       saturating count of hits accepted in IDLE
//   perf_miss_count      saturating count of refills started
// ----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        icache_query_en,
    input  logic [31:0] icache_query_pc,
    output logic        icache_data_en,
    output logic [31:0] icache_addr_comfirm,
    output logic [31:0] icache_data,
    output logic        mem_req_en,
    output logic [31:0] mem_req_addr,
    input  logic        mem_data_en,
    input  logic [31:0] mem_data
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_hit_count,
    output logic [31:0] perf_miss_count
`endif
);

    localparam int TAG_WIDTH = 32 - 2 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam int LINE_LSB  = OFFSET_WIDTH + 2;
    localparam int TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REFILL  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Storage
    logic [31:0]          data_arr [LINES][WORDS];
    logic [TAG_WIDTH-1:0] tag_arr  [LINES];
    logic [LINES-1:0]     valid;

    // Word address (pc[31:2]) of the query that missed
    logic [31:2]             miss_pc;
    logic [OFFSET_WIDTH-1:0] refill_cnt;

    // Address fields of the incoming query and of the pending miss
    logic [OFFSET_WIDTH-1:0] q_offset;
    logic [INDEX_WIDTH-1:0]  q_index;
    logic [TAG_WIDTH-1:0]    q_tag;
    logic [OFFSET_WIDTH-1:0] m_offset;
    logic [INDEX_WIDTH-1:0]  m_index;
    logic [TAG_WIDTH-1:0]    m_tag;

    logic lookup_hit;
    logic accept;
    logic hit_accept;
    logic miss_accept;
    logic fill_beat;
    logic last_beat;
    logic respond_hit;

    // Byte-lane bits of the pc carry no information for a word cache
    logic unused_pc_bits;
    assign unused_pc_bits = ^icache_query_pc[1:0];

    assign q_offset = icache_query_pc[LINE_LSB-1:2];
    assign q_index  = icache_query_pc[TAG_LSB-1:LINE_LSB];
    assign q_tag    = icache_query_pc[31:TAG_LSB];
    assign m_offset = miss_pc[LINE_LSB-1:2];
    assign m_index  = miss_pc[TAG_LSB-1:LINE_LSB];
    assign m_tag    = miss_pc[31:TAG_LSB];

    assign lookup_hit = valid[q_index] && (tag_arr[q_index] == q_tag);

    // A query is not re-accepted while its own response pulse is on the
    // output, which absorbs a fetcher that drops query_en one edge late.
    assign accept      = (state == S_IDLE) && icache_query_en && !icache_data_en;
    assign hit_accept  = accept && lookup_hit;
    assign miss_accept = accept && !lookup_hit;

    // mem_data_en only counts while a request is outstanding
    assign fill_beat = (state == S_REFILL) && mem_req_en && mem_data_en;
    assign last_beat = fill_beat && (&refill_cnt);

    // The response after a refill uses whatever query is visible in RESPOND,
    // so a withdrawn or redirected fetch never receives a stale word.
    assign respond_hit = (state == S_RESPOND) && icache_query_en
                         && (icache_query_pc[31:2] == miss_pc);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (miss_accept) state_nxt = S_REFILL;
            S_REFILL:  if (last_beat)   state_nxt = S_RESPOND;
            S_RESPOND: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Control and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid               <= '0;
            icache_data_en      <= 1'b0;
            icache_addr_comfirm <= 32'd0;
            icache_data         <= 32'd0;
            mem_req_en          <= 1'b0;
            mem_req_addr        <= 32'd0;
            refill_cnt          <= '0;
        end else if (rdy_in) begin
            icache_data_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hit_accept) begin
                        icache_data_en      <= 1'b1;
                        icache_data         <= data_arr[q_index][q_offset];
                        icache_addr_comfirm <= {icache_query_pc[31:2], 2'b00};
                    end else if (miss_accept) begin
                        // The line is invalid until every word has arrived
                        valid[q_index] <= 1'b0;
                        mem_req_en     <= 1'b1;
                        mem_req_addr   <= {icache_query_pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
                        refill_cnt     <= '0;
                    end
                end
                S_REFILL: begin
                    if (fill_beat) begin
                        refill_cnt <= refill_cnt + OFFSET_WIDTH'(1);
                        if (&refill_cnt) begin
                            mem_req_en     <= 1'b0;
                            valid[m_index] <= 1'b1;
                        end else begin
                            mem_req_addr <= mem_req_addr + 32'd4;
                        end
                    end
                end
                S_RESPOND: begin
                    if (respond_hit) begin
                        icache_data_en      <= 1'b1;
                        icache_data         <= data_arr[m_index][m_offset];
                        icache_addr_comfirm <= {miss_pc, 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

    // Data path storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (miss_accept) begin
                miss_pc <= icache_query_pc[31:2];
            end
            if (fill_beat) begin
                data_arr[m_index][refill_cnt] <= mem_data;
            end
            if (last_beat) begin
                tag_arr[m_index] <= m_tag;
            end
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_hit_count  <= 32'd0;
            perf_miss_count <= 32'd0;
        end else if (rdy_in) begin
            if (hit_accept) begin
                perf_hit_count <= sat_inc(perf_hit_count);
            end
            if (miss_accept) begin
                perf_miss_count <= sat_inc(perf_miss_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
module tb_icache_direct_mapped;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        icache_query_en = 1'b0;
    logic [31:0] icache_query_pc = 32'd0;
    logic        icache_data_en;
    logic [31:0] icache_addr_comfirm;
    logic [31:0] icache_data;
    logic        mem_req_en;
    logic [31:0] mem_req_addr;
    logic        mem_data_en = 1'b0;
    logic [31:0] mem_data = 32'd0;

    icache_direct_mapped dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .icache_query_en     (icache_query_en),
        .icache_query_pc     (icache_query_pc),
        .icache_data_en      (icache_data_en),
        .icache_addr_comfirm (icache_addr_comfirm),
        .icache_data         (icache_data),
        .mem_req_en          (mem_req_en),
        .mem_req_addr        (mem_req_addr),
        .mem_data_en         (mem_data_en),
        .mem_data            (mem_data)
    );

    always #5 clk_in = ~clk_in;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: which memory line each cache slot currently holds.
    // Memory is read-only, so a served word always equals mem_word(address).
    bit          mv [16];
    logic [31:0] mt [16];

    // Memory-side bookkeeping
    int          mem_k;
    logic [31:0] exp_base;
    bit          no_mem;
    bit          serve_en;
    int          pulses;
    logic [31:0] last_data;
    logic [31:0] last_conf;
    bit          cur_hit;
    int          cur_lat;
    logic [31:0] cur_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge, then drive the memory side
    task automatic cycle();
        @(negedge clk_in);
        if (icache_data_en === 1'b1) begin
            pulses++;
            last_data = icache_data;
            last_conf = icache_addr_comfirm;
        end
        if (no_mem && mem_req_en !== 1'b0)
            check("no_mem_on_hit", {31'd0, mem_req_en}, 32'd0);
        mem_data_en = 1'b0;
        if (serve_en && rdy_in && mem_req_en === 1'b1 && $urandom_range(0, 1) == 1) begin
            check("mem_addr", mem_req_addr, exp_base + 32'(4 * mem_k));
            mem_data_en = 1'b1;
            mem_data    = mem_word(mem_req_addr);
            mem_k++;
        end
    endtask

    task automatic start_query(input logic [31:0] pc);
        int idx;
        idx       = int'((pc >> 4) % 16);
        cur_hit   = mv[idx] && (mt[idx] == (pc >> 8));
        cur_pc    = pc;
        exp_base  = pc & ~32'hF;
        mem_k     = 0;
        no_mem    = cur_hit;
        pulses    = 0;
        cur_lat   = 0;
        icache_query_pc = pc;
        icache_query_en = 1'b1;
    endtask

    task automatic wait_pulse();
        while (pulses == 0 && cur_lat < 300) begin
            cycle();
            cur_lat++;
        end
    endtask

    task automatic finish_query(input bit late);
        int idx;
        idx = int'((cur_pc >> 4) % 16);
        check("served", 32'(pulses), 32'd1);
        check("data", last_data, mem_word(cur_pc & ~32'h3));
        check("confirm", last_conf, cur_pc & ~32'h3);
        check("refill_words", 32'(mem_k), cur_hit ? 32'd0 : 32'd4);
        check("req_after", {31'd0, mem_req_en}, 32'd0);
        if (cur_hit) check("hit_latency", 32'(cur_lat), 32'd1);
        if (late) cycle();
        icache_query_en = 1'b0;
        cycle();
        check("single_pulse", 32'(pulses), 32'd1);
        no_mem  = 1'b0;
        mv[idx] = 1'b1;
        mt[idx] = cur_pc >> 8;
    endtask

    task automatic run_query(input logic [31:0] pc, input bit late);
        start_query(pc);
        wait_pulse();
        finish_query(late);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        logic [31:0] pc;
        for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = 32'd0; end
        serve_en = 1'b1;
        no_mem   = 1'b0;
        mem_k    = 0;
        exp_base = 32'd0;
        pulses   = 0;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_data_en", {31'd0, icache_data_en}, 32'd0);
        check("rst_confirm", icache_addr_comfirm, 32'd0);
        check("rst_data", icache_data, 32'd0);
        check("rst_req_en", {31'd0, mem_req_en}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        rst_in = 1'b0;

        // Cold miss, then hits in the same line with a late query drop
        run_query(32'h0000_0008, 1'b0);
        run_query(32'h0000_000C, 1'b1);
        run_query(32'h0000_0000, 1'b0);

        // Conflict eviction: 0x100 shares index 0 with 0x0
        run_query(32'h0000_0100, 1'b0);
        run_query(32'h0000_0000, 1'b0);

        // Flush mid-refill: query withdrawn after the second word
        start_query(32'h0000_0020);
        n = 0;
        while (mem_k < 2 && n < 300) begin cycle(); n++; end
        icache_query_en = 1'b0;
        while (mem_k < 4 && n < 600) begin cycle(); n++; end
        repeat (4) cycle();
        check("flush_words", 32'(mem_k), 32'd4);
        check("flush_no_resp", 32'(pulses), 32'd0);
        check("flush_req_idle", {31'd0, mem_req_en}, 32'd0);
        mv[2] = 1'b1;
        mt[2] = 32'd0;
        run_query(32'h0000_0024, 1'b0);

        // rdy_in stall during refill with spurious mem_data_en pulses
        start_query(32'h0000_0054);
        n = 0;
        while (mem_k < 1 && n < 300) begin cycle(); n++; end
        serve_en = 1'b0;
        cycle();
        held = mem_req_addr;
        check("stall_pre_addr", held, 32'h0000_0054);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_data_en = 1'b1;
            mem_data    = 32'hDEAD_BEEF;
            @(negedge clk_in);
            check("stall_addr", mem_req_addr, 32'h0000_0054);
            check("stall_req_en", {31'd0, mem_req_en}, 32'd1);
        end
        mem_data_en = 1'b0;
        rdy_in   = 1'b1;
        serve_en = 1'b1;
        wait_pulse();
        finish_query(1'b0);

        // Line at the very top of the address space
        run_query(32'hFFFF_FFF8, 1'b0);
        run_query(32'hFFFF_FFFC, 1'b1);

        // Asynchronous reset between edges in the middle of a refill
        start_query(32'h0000_0064);
        n = 0;
        while (mem_k < 2 && n < 300) begin cycle(); n++; end
        serve_en = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("arst_req_en", {31'd0, mem_req_en}, 32'd0);
        check("arst_data_en", {31'd0, icache_data_en}, 32'd0);
        check("arst_req_addr", mem_req_addr, 32'd0);
        mem_data_en     = 1'b0;
        icache_query_en = 1'b0;
        @(negedge clk_in);
        rst_in   = 1'b0;
        serve_en = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        run_query(32'h0000_0008, 1'b0);
        run_query(32'h0000_0064, 1'b0);

        // Randomized traffic over a few tags so hits and conflicts both occur
        for (int q = 0; q < 60; q++) begin
            pc = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            run_query(pc, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
